capture_line_reader: RTL

// - Host-side initiator for the image-capture manager: arms the manager (start/configuration),

---
 rtl/capture_pkg.sv | 29 ++
 rtl/capture_byte_packer.sv | 34 +++
 rtl/capture_line_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types and widths for the capture line reader.
package capture_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int LANE_W         = $clog2(BYTES_PER_WORD);
   localparam int LINE_CNT_W     = 16;
   localparam int BYTE_CNT_W     = 16;
   localparam int LAT_CNT_W      = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARM       = 3'd1,
      ST_WAIT_LINE = 3'd2,
      ST_REQ       = 3'd3,
      ST_LAT       = 3'd4,
      ST_PACK      = 3'd5,
      ST_PUSH      = 3'd6,
      ST_STOP      = 3'd7
   } capture_state_t;

   // A new line showing up in any of these states arrives before the
   // previous one has been fully handed downstream.
   function automatic logic is_overrun_state(capture_state_t s);
      return (s != ST_IDLE) && (s != ST_WAIT_LINE);
   endfunction

endpackage

// File: rtl/capture_byte_packer.sv
// Collects bytes into one output word; lanes never written stay zero
// because the word is cleared whenever it is accepted downstream.
module capture_byte_packer
   import capture_pkg::*;
(
   input  logic              clk,
   input  logic              resetN,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic [LANE_W-1:0] i_lane,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_word
);

   logic [WORD_W-1:0] r_word;

   // Clear has priority so an accepted word never leaks into the next group.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_word <= '0;
      end else if (i_clear) begin
         r_word <= '0;
      end else if (i_load) begin
         for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (i_lane == LANE_W'(i)) begin
               r_word[i*BYTE_W +: BYTE_W] <= i_byte;
            end
         end
      end
   end

   assign o_word = r_word;

endmodule

// File: rtl/capture_line_reader.sv
// Host-side reader for the image-capture manager: arms it, drains each
// captured line byte by byte and streams the bytes out as 32-bit words.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for a fresh rising edge on enable
// ARM       | start pulse; clear overrun, line and byte counters
// WAIT_LINE | waiting for lineCaptured; leaves for STOP if enable low
// REQ       | getData pulse, latency counter loaded
// LAT       | waiting for the requested byte, samples it on terminal count
// PACK      | advance byte lane/count, decide whether a word is complete
// PUSH      | word presented on outWord/outValid until outReady
// STOP      | stop pulse, then back to IDLE
module capture_line_reader
   import capture_pkg::*;
#(
   parameter int LINE_BYTES   = 640,
   parameter int DATA_LATENCY = 1
)(
   input  logic                  clk,
   input  logic                  resetN,
   input  logic                  enable,
   input  logic [WORD_W-1:0]     configIn,
   output logic                  start,
   output logic                  stop,
   output logic [WORD_W-1:0]     configuration,
   input  logic                  lineCaptured,
   output logic                  getData,
   input  logic [BYTE_W-1:0]     data,
   output logic [WORD_W-1:0]     outWord,
   output logic                  outValid,
   input  logic                  outReady,
   output logic                  outLast,
   output logic [LINE_CNT_W-1:0] lineCount,
   output logic                  busy,
   output logic                  overrun
);

   localparam logic [BYTE_CNT_W-1:0] LP_LINE_BYTES = BYTE_CNT_W'(LINE_BYTES);
   localparam logic [LAT_CNT_W-1:0]  LP_LAT_LOAD   = LAT_CNT_W'(DATA_LATENCY - 1);

   capture_state_t          r_state;
   capture_state_t          w_state_nxt;

   logic                    r_enable_d;
   logic                    r_lc_d;
   logic [WORD_W-1:0]       r_config;
   logic [LAT_CNT_W-1:0]    r_lat_cnt;
   logic [BYTE_CNT_W-1:0]   r_byte_cnt;
   logic [LANE_W-1:0]       r_byte_idx;
   logic [LINE_CNT_W-1:0]   r_line_cnt;
   logic                    r_overrun;

   logic                    w_enable_rise;
   logic                    w_lc_rise;
   logic                    w_lat_done;
   logic [BYTE_CNT_W-1:0]   w_byte_cnt_inc;
   logic                    w_word_full;
   logic                    w_line_end;
   logic                    w_last;
   logic                    w_accept;
   logic                    w_pk_load;
   logic                    w_pk_clear;
   logic [WORD_W-1:0]       w_pk_word;

   assign w_enable_rise  = enable & ~r_enable_d;
   assign w_lc_rise      = lineCaptured & ~r_lc_d;
   assign w_lat_done     = (r_lat_cnt == '0);
   assign w_byte_cnt_inc = r_byte_cnt + BYTE_CNT_W'(1);
   assign w_word_full    = (r_byte_idx == LANE_W'(BYTES_PER_WORD - 1));
   assign w_line_end     = (w_byte_cnt_inc == LP_LINE_BYTES);
   // In PUSH the byte counter already includes every byte of the word.
   assign w_last         = (r_byte_cnt == LP_LINE_BYTES);

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      w_state_nxt = r_state;
      start       = 1'b0;
      stop        = 1'b0;
      getData     = 1'b0;
      outValid    = 1'b0;
      outLast     = 1'b0;
      busy        = 1'b1;
      w_accept    = 1'b0;
      w_pk_load   = 1'b0;
      w_pk_clear  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            busy = 1'b0;
            if (w_enable_rise) begin
               w_state_nxt = ST_ARM;
            end
         end
         ST_ARM: begin
            start       = 1'b1;
            w_pk_clear  = 1'b1;
            w_state_nxt = ST_WAIT_LINE;
         end
         ST_WAIT_LINE: begin
            if (!enable) begin
               w_state_nxt = ST_STOP;
            end else if (lineCaptured) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            getData     = 1'b1;
            w_state_nxt = ST_LAT;
         end
         ST_LAT: begin
            if (w_lat_done) begin
               w_pk_load   = 1'b1;
               w_state_nxt = ST_PACK;
            end
         end
         ST_PACK: begin
            if (w_word_full || w_line_end) begin
               w_state_nxt = ST_PUSH;
            end else begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_PUSH: begin
            outValid = 1'b1;
            outLast  = w_last;
            if (outReady) begin
               w_accept    = 1'b1;
               w_pk_clear  = 1'b1;
               w_state_nxt = w_last ? ST_WAIT_LINE : ST_REQ;
            end
         end
         ST_STOP: begin
            stop        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Previous-cycle copies of enable and lineCaptured for edge detection.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_enable_d <= 1'b0;
         r_lc_d     <= 1'b0;
      end else begin
         r_enable_d <= enable;
         r_lc_d     <= lineCaptured;
      end
   end

   // Configuration is captured only on the edge that starts a session.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_config <= '0;
      end else if ((r_state == ST_IDLE) && w_enable_rise) begin
         r_config <= configIn;
      end
   end

   // Down-counter spacing getData and the data sample.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_lat_cnt <= '0;
      end else if (r_state == ST_REQ) begin
         r_lat_cnt <= LP_LAT_LOAD;
      end else if ((r_state == ST_LAT) && !w_lat_done) begin
         r_lat_cnt <= r_lat_cnt - LAT_CNT_W'(1);
      end
   end

   // Byte position within the line and lane within the current word.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_byte_cnt <= '0;
         r_byte_idx <= '0;
      end else if (r_state == ST_ARM) begin
         r_byte_cnt <= '0;
         r_byte_idx <= '0;
      end else if (r_state == ST_PACK) begin
         r_byte_cnt <= w_byte_cnt_inc;
         r_byte_idx <= r_byte_idx + LANE_W'(1);
      end else if (w_accept && w_last) begin
         r_byte_cnt <= '0;
         r_byte_idx <= '0;
      end
   end

   // Lines fully handed downstream since the last start.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_line_cnt <= '0;
      end else if (r_state == ST_ARM) begin
         r_line_cnt <= '0;
      end else if (w_accept && w_last) begin
         r_line_cnt <= r_line_cnt + LINE_CNT_W'(1);
      end
   end

   // Sticky overrun flag; the line in progress is not disturbed by it.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_overrun <= 1'b0;
      end else if (r_state == ST_ARM) begin
         r_overrun <= 1'b0;
      end else if (w_lc_rise && is_overrun_state(r_state)) begin
         r_overrun <= 1'b1;
      end
   end

   capture_byte_packer u_packer (
      .clk     (clk),
      .resetN  (resetN),
      .i_clear (w_pk_clear),
      .i_load  (w_pk_load),
      .i_lane  (r_byte_idx),
      .i_byte  (data),
      .o_word  (w_pk_word)
   );

   assign configuration = r_config;
   assign outWord       = w_pk_word;
   assign lineCount     = r_line_cnt;
   assign overrun       = r_overrun;

endmodule
